imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Registered immediate generator covering every RV32I format (I/S/B/U/J) plus RV32C compressed immediates.
//  Sits between fetch/align and the decode/ID register; takes one instruction per valid/ready beat.
//  Returns the sign- or zero-extended immediate, a format code and a compressed flag.
//  Generalises the 12-bit I/S/B-only generator: adds U/J, RVC, an XLEN parameter and flow control.
// PARAMETERS
//  XLEN      32  immediate output width; legal values are 32 and 64; extension fills bits XLEN-1..32
//  ENABLE_C  1   1: decode RVC when inst[1:0]!=2'b11. 0: such inst gives fmt=FMT_NONE, imm=0
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     inst holds a valid instruction (upper 16 bits ignored when compressed)
//  in_ready   out  1     block accepts this cycle
//  inst       in   32    instruction word
//  out_valid  out  1     imm/fmt/comp valid
//  out_ready  in   1     consumer accepts this cycle
//  imm        out  XLEN  generated immediate
//  fmt        out  3     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CI (compressed, sign-ext), 7 CZ (compressed, zero-ext/scaled)
//  comp       out  1     instruction was 16-bit
// BEHAVIOUR
//  Reset: out_valid=0, imm=0, fmt=0, comp=0, in_ready=1 in the following cycle.
//  Handshake:
//   - Single output register; in_ready = !out_valid | out_ready (combinational pass-back).
//   - Accept on in_valid&in_ready; result appears next cycle (latency 1).
//   - A full throughput of 1/clk is sustained while out_ready=1.
//   - out_valid holds and imm/fmt/comp hold stable while out_valid&!out_ready.
//   - Transfer and accept in the same cycle replace the register contents (no bubble).
//   - out_valid clears only on a transfer with no new accept.
//  RV32I decode on opcode inst[6:0]:
//   - 0000011/0010011/1100111 -> I: sext(inst[31:20])
//   - 0100011 -> S: sext({inst[31:25],inst[11:7]})
//   - 1100011 -> B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
//   - 0110111/0010111 -> U: sext({inst[31:12],12'b0})
//   - 1101111 -> J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
//   - any other opcode -> NONE, imm=0
//  RVC decode on (inst[1:0], inst[15:13]); any other pair -> NONE, imm=0:
//   - q0 000 ADDI4SPN -> CZ {inst[10:7],inst[12:11],inst[5],inst[6],2'b0}
//   - q0 010/110 LW/SW -> CZ {inst[5],inst[12:10],inst[6],2'b0}
//   - q1 000/010 ADDI/LI -> CI sext({inst[12],inst[6:2]})
//   - q1 011, rd=2: ADDI16SP -> CI sext({inst[12],inst[4:3],inst[5],inst[2],inst[6],4'b0})
//   - q1 011, rd!=2: LUI -> CI sext({inst[12],inst[6:2],12'b0})
//   - q1 001/101 JAL/J -> CI sext({inst[12],inst[8],inst[10:9],inst[6],inst[7],inst[2],inst[11],inst[5:3],1'b0})
//   - q1 110/111 BEQZ/BNEZ -> CI sext({inst[12],inst[6:5],inst[2],inst[11:10],inst[4:3],1'b0})
//   - q2 000 SLLI -> CZ {inst[12],inst[6:2]}
//   - q2 010 LWSP -> CZ {inst[3:2],inst[12],inst[6:4],2'b0}
//   - q2 110 SWSP -> CZ {inst[8:7],inst[12:9],2'b0}
//  Reserved encodings (zero-imm ADDI4SPN etc.) are not flagged; legality is checked in decode.
//  rst mid-operation: the pending result is dropped and out_valid=0 next cycle; in_valid during rst is ignored.
// STRUCTURE
//  Shared package riscv_pkg holds the fmt localparams (FMT_NONE..FMT_CZ) and the opcode/quadrant constants.
//  One combinational sub-module imm_decode_comb (inst -> imm, fmt, comp).
//  imm_gen_pipe = imm_decode_comb + handshake/output register.
// TESTING
//  1 BEQ 0xFE000EE3, out_ready=1 -> next cycle imm=0xFFFFFFFC, fmt=3, comp=0.
//  2 LUI 0x123450B7 -> 0x12345000 fmt=4; JAL 0x0080006F -> 0x00000008 fmt=5, issued back-to-back at 1/clk.
//  3 C.LI 0x000050FD -> imm=0xFFFFFFFF fmt=6 comp=1; ENABLE_C=0 same inst -> imm=0 fmt=0.
//  4 Backpressure: out_ready=0 for 3 cycles after a SW beat -> in_ready=0, outputs frozen.
//    Release -> next queued beat follows in the next cycle with no loss or duplication.
//  5 rst asserted while out_valid=1, out_ready=0 -> out_valid=0, imm=0 next cycle; in_ready=1 once rst drops.
//  6 XLEN=64, J with inst[31]=1 -> imm[63:20] all ones; random opcodes vs reference-model scoreboard.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: immediate format codes, base opcodes and RVC quadrants.
package riscv_pkg;

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_CI   = 3'd6;
   localparam logic [2:0] FMT_CZ   = 3'd7;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] QUAD_C0   = 2'b00;
   localparam logic [1:0] QUAD_C1   = 2'b01;
   localparam logic [1:0] QUAD_C2   = 2'b10;
   localparam logic [1:0] QUAD_RV32 = 2'b11;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate extraction for RV32I and RV32C encodings.
module imm_decode_comb
   import riscv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_C = 1'b1
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            comp
);

   logic signed [31:0] imm32;
   logic [1:0]         quad;
   logic [2:0]         funct3c;

   assign quad    = inst[1:0];
   assign funct3c = inst[15:13];

   always_comb begin
      imm32 = '0;
      fmt   = FMT_NONE;
      comp  = (quad != QUAD_RV32);
      if (!comp) begin
         case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
               imm32 = {{20{inst[31]}}, inst[31:20]};
               fmt   = FMT_I;
            end
            OP_STORE: begin
               imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
               fmt   = FMT_S;
            end
            OP_BRANCH: begin
               imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
               fmt   = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
               imm32 = {inst[31:12], 12'b0};
               fmt   = FMT_U;
            end
            OP_JAL: begin
               imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
               fmt   = FMT_J;
            end
            default: ;
         endcase
      end else if (ENABLE_C) begin
         // Reserved encodings still yield their immediate; legality is judged downstream.
         case ({quad, funct3c})
            {QUAD_C0, 3'b000}: begin
               imm32 = {22'b0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b0};
               fmt   = FMT_CZ;
            end
            {QUAD_C0, 3'b010}, {QUAD_C0, 3'b110}: begin
               imm32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b0};
               fmt   = FMT_CZ;
            end
            {QUAD_C1, 3'b000}, {QUAD_C1, 3'b010}: begin
               imm32 = {{26{inst[12]}}, inst[12], inst[6:2]};
               fmt   = FMT_CI;
            end
            {QUAD_C1, 3'b011}: begin
               if (inst[11:7] == 5'd2) begin
                  imm32 = {{22{inst[12]}}, inst[12], inst[4:3], inst[5], inst[2], inst[6], 4'b0};
               end else begin
                  imm32 = {{14{inst[12]}}, inst[12], inst[6:2], 12'b0};
               end
               fmt = FMT_CI;
            end
            {QUAD_C1, 3'b001}, {QUAD_C1, 3'b101}: begin
               imm32 = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                        inst[2], inst[11], inst[5:3], 1'b0};
               fmt   = FMT_CI;
            end
            {QUAD_C1, 3'b110}, {QUAD_C1, 3'b111}: begin
               imm32 = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
               fmt   = FMT_CI;
            end
            {QUAD_C2, 3'b000}: begin
               imm32 = {26'b0, inst[12], inst[6:2]};
               fmt   = FMT_CZ;
            end
            {QUAD_C2, 3'b010}: begin
               imm32 = {24'b0, inst[3:2], inst[12], inst[6:4], 2'b0};
               fmt   = FMT_CZ;
            end
            {QUAD_C2, 3'b110}: begin
               imm32 = {24'b0, inst[8:7], inst[12:9], 2'b0};
               fmt   = FMT_CZ;
            end
            default: ;
         endcase
      end
   end

   // Zero-extended forms never set bit 31, so one sign extension serves every format.
   assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a single valid/ready output register (latency 1, full throughput).
module imm_gen_pipe
   import riscv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_C = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            comp
);

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_comp;

   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [2:0]      fmt_q, fmt_d;
   logic            comp_q, comp_d;
   logic            accept;

   imm_decode_comb #(
      .XLEN     (XLEN),
      .ENABLE_C (ENABLE_C)
   ) u_decode (
      .inst (inst),
      .imm  (dec_imm),
      .fmt  (dec_fmt),
      .comp (dec_comp)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      imm_d       = imm_q;
      fmt_d       = fmt_q;
      comp_d      = comp_q;
      if (accept) begin
         out_valid_d = 1'b1;
         imm_d       = dec_imm;
         fmt_d       = dec_fmt;
         comp_d      = dec_comp;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         imm_q       <= '0;
         fmt_q       <= FMT_NONE;
         comp_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         imm_q       <= imm_d;
         fmt_q       <= fmt_d;
         comp_q      <= comp_d;
      end
   end

   assign out_valid = out_valid_q;
   assign imm       = imm_q;
   assign fmt       = fmt_q;
   assign comp      = comp_q;

endmodule
